// File: rtl/data_sram_resp.sv
// data_sram_resp: byte-lane RAM plus LED/SWITCH/SCRATCH/TIMER peripherals, 1-cycle registered read.
// Define SRAM_RESP_TIMER_EN to build the free-running TIMER at offset 0xE000.
module data_sram_resp #(
  parameter int RAM_ADDR_W = 14
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] led,
  input  logic [7:0]  switch
);
  localparam logic [15:0] OFF_LED     = 16'hF000;
  localparam logic [15:0] OFF_SWITCH  = 16'hF004;
  localparam logic [15:0] OFF_SCRATCH = 16'hF008;
  localparam logic [15:0] OFF_TIMER   = 16'hE000;
  logic [31:0]           r_mem [2**RAM_ADDR_W];
  logic [15:0]           r_led;
  logic [31:0]           r_scratch;
  logic [7:0]            r_sw_meta;
  logic [7:0]            r_sw_sync;
  logic                  w_acc;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_periph;
  logic [15:0]           w_off;
  logic [RAM_ADDR_W-1:0] w_idx;
  logic [31:0]           w_mask;
  logic [31:0]           w_timer;
  logic [31:0]           w_prdata;
  logic                  w_wr_led;
  logic                  w_wr_scratch;
  // Accesses presented while in reset are dropped entirely.
  assign w_acc        = data_sram_en & resetn;
  assign w_wr         = w_acc & (|data_sram_wen);
  assign w_rd         = w_acc & ~(|data_sram_wen);
  assign w_periph     = data_sram_addr[31:16] == 16'hBFAF;
  assign w_off        = data_sram_addr[15:0];
  assign w_idx        = data_sram_addr[RAM_ADDR_W+1:2];
  assign w_mask       = {{8{data_sram_wen[3]}}, {8{data_sram_wen[2]}},
                         {8{data_sram_wen[1]}}, {8{data_sram_wen[0]}}};
  assign w_wr_led     = w_wr & w_periph & (w_off == OFF_LED);
  assign w_wr_scratch = w_wr & w_periph & (w_off == OFF_SCRATCH);
  always_ff @(posedge clk) begin
    if (w_wr && !w_periph)
      for (int i = 0; i < 4; i++)
        if (data_sram_wen[i]) r_mem[w_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_led     <= '0;
      r_scratch <= '0;
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= switch;
      r_sw_sync <= r_sw_meta;
      if (w_wr_led) r_led <= (r_led & ~w_mask[15:0]) | (data_sram_wdata[15:0] & w_mask[15:0]);
      if (w_wr_scratch) r_scratch <= (r_scratch & ~w_mask) | (data_sram_wdata & w_mask);
    end
  end
`ifdef SRAM_RESP_TIMER_EN
  logic [31:0] r_timer;
  logic        w_wr_timer;
  assign w_wr_timer = w_wr & w_periph & (w_off == OFF_TIMER);
  // Unwritten lanes keep the pre-increment value; a write suppresses this cycle's increment.
  always_ff @(posedge clk) begin
    if (!resetn) r_timer <= '0;
    else if (w_wr_timer) r_timer <= (r_timer & ~w_mask) | (data_sram_wdata & w_mask);
    else r_timer <= r_timer + 32'd1;
  end
  assign w_timer = r_timer;
`else
  assign w_timer = '0;
`endif
  always_comb begin
    w_prdata = (w_off == OFF_LED)     ? {16'h0, r_led} :
               (w_off == OFF_SWITCH)  ? {24'h0, r_sw_sync} :
               (w_off == OFF_SCRATCH) ? r_scratch :
               (w_off == OFF_TIMER)   ? w_timer : 32'h0;
  end
  always_ff @(posedge clk) begin
    if (!resetn) data_sram_rdata <= '0;
    else if (w_rd) data_sram_rdata <= w_periph ? w_prdata : r_mem[w_idx];
  end
  assign led = r_led;
endmodule

// File: tb/tb_data_sram_resp.sv
// tb_data_sram_resp: directed checks of RAM, peripherals, timer and reset behaviour.
module tb_data_sram_resp;
  logic        clk = 1'b0;
  logic        resetn;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic [15:0] led;
  logic [7:0]  switch;
  int n_cmp = 0;
  int n_err = 0;
  data_sram_resp dut (
    .clk(clk), .resetn(resetn), .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata), .led(led), .switch(switch)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask
  task automatic acc(input logic en, input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wd);
    data_sram_en = en;
    data_sram_wen = wen;
    data_sram_addr = addr;
    data_sram_wdata = wd;
    @(posedge clk);
    #1;
    data_sram_en = 1'b0;
    data_sram_wen = 4'h0;
  endtask
  task automatic wr(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wd);
    acc(1'b1, wen, addr, wd);
  endtask
  task automatic rd(input logic [31:0] addr);
    acc(1'b1, 4'h0, addr, 32'h0);
  endtask
  task automatic idle();
    acc(1'b0, 4'h0, 32'h0, 32'h0);
  endtask
  initial begin
    resetn = 1'b0;
    switch = 8'h00;
    data_sram_en = 1'b0;
    data_sram_wen = 4'h0;
    data_sram_addr = 32'h0;
    data_sram_wdata = 32'h0;
    idle();
    idle();
    check("reset_rdata", data_sram_rdata, 32'h0);
    check("reset_led", {16'h0, led}, 32'h0);
    resetn = 1'b1;
    wr(32'h0000_0010, 4'hF, 32'hDEAD_BEEF);
    rd(32'h0000_0010);
    check("ram_rd_after_wr", data_sram_rdata, 32'hDEAD_BEEF);
    idle();
    check("hold_idle", data_sram_rdata, 32'hDEAD_BEEF);
    wr(32'h0000_0014, 4'hF, 32'h0102_0304);
    check("hold_write", data_sram_rdata, 32'hDEAD_BEEF);
    wr(32'h0000_0020, 4'hF, 32'h1122_3344);
    wr(32'h0000_0020, 4'b0101, 32'hAABB_CCDD);
    rd(32'h0000_0020);
    check("ram_lanes", data_sram_rdata, 32'h11BB_33DD);
    rd(32'h0001_0022);
    check("ram_alias", data_sram_rdata, 32'h11BB_33DD);
    rd(32'h0000_0014);
    check("ram_other_word", data_sram_rdata, 32'h0102_0304);
    wr(32'hBFAF_F000, 4'hF, 32'h0000_A5A5);
    check("led_out", {16'h0, led}, 32'h0000_A5A5);
    rd(32'hBFAF_F000);
    check("led_rd", data_sram_rdata, 32'h0000_A5A5);
    rd(32'hBFAF_0100);
    check("unmapped_rd", data_sram_rdata, 32'h0);
    wr(32'hBFAF_F000, 4'b0010, 32'hFFFF_3C77);
    check("led_lane", {16'h0, led}, 32'h0000_3CA5);
    wr(32'hBFAF_F008, 4'hF, 32'hCAFE_F00D);
    wr(32'hBFAF_F008, 4'b1000, 32'h1122_3344);
    rd(32'hBFAF_F008);
    check("scratch_lane", data_sram_rdata, 32'h11FE_F00D);
    switch = 8'h3C;
    idle();
    idle();
    idle();
    rd(32'hBFAF_F004);
    check("switch_rd", data_sram_rdata, 32'h0000_003C);
    wr(32'hBFAF_F004, 4'hF, 32'hFFFF_FFFF);
    rd(32'hBFAF_F004);
    check("switch_ro", data_sram_rdata, 32'h0000_003C);
    wr(32'hBFAF_E000, 4'hF, 32'hFFFF_FFFE);
    idle();
    rd(32'hBFAF_E000);
`ifdef SRAM_RESP_TIMER_EN
    check("timer_rd1", data_sram_rdata, 32'hFFFF_FFFF);
`else
    check("timer_rd1", data_sram_rdata, 32'h0);
`endif
    idle();
    rd(32'hBFAF_E000);
`ifdef SRAM_RESP_TIMER_EN
    check("timer_wrap", data_sram_rdata, 32'h0000_0001);
`else
    check("timer_wrap", data_sram_rdata, 32'h0);
`endif
    wr(32'h0000_0040, 4'hF, 32'h55AA_55AA);
    resetn = 1'b0;
    wr(32'h0000_0040, 4'hF, 32'hFFFF_FFFF);
    check("rst_rdata", data_sram_rdata, 32'h0);
    check("rst_led", {16'h0, led}, 32'h0);
    rd(32'h0000_0040);
    check("rst_no_read", data_sram_rdata, 32'h0);
    resetn = 1'b1;
    rd(32'hBFAF_F008);
    check("rst_scratch", data_sram_rdata, 32'h0);
    rd(32'h0000_0040);
    check("rst_ram_kept", data_sram_rdata, 32'h55AA_55AA);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/data_sram_resp.md
DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 SHALL have parameter: RAM_ADDR_W, 14, RAM word-address width (2^RAM_ADDR_W 32-bit words).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: resetn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: data_sram_en  input  1  access request this cycle.
REQ-005 SHALL have port: data_sram_wen  input  4  byte-lane write enables; nonzero = write, zero = read.
REQ-006 SHALL have port: data_sram_addr  input  32  byte address; bits [1:0] ignored.
REQ-007 SHALL have port: data_sram_wdata  input  32  write data, lane i = bits [8i+7:8i].
REQ-008 SHALL have port: data_sram_rdata  output  32  read data, registered.
REQ-009 SHALL have port: led  output  16  LED register contents.
REQ-010 SHALL have port: switch  input  8  asynchronous switch inputs.

Function
REQ-011 SHALL decode: addr[31:16]==16'hBFAF -> peripheral region; else RAM region, word index addr[RAM_ADDR_W+1:2], higher bits ignored (aliasing).
REQ-012 SHALL perform a write when en=1 and wen!=0: only lanes with wen[i]=1 updated; other lanes unchanged.
REQ-013 SHALL perform a read when en=1 and wen=0: rdata updated exactly one cycle later (latency 1).
REQ-014 SHALL hold rdata unchanged in cycles following a write or en=0.
REQ-015 SHALL return newly written data on a read issued the cycle after a write to the same address (no stale read).
REQ-016 SHALL map peripheral offsets addr[15:0]: 0xF000 LED (RW, bits 15:0, upper bits read 0); 0xF004 SWITCH (RO, zero-extended); 0xF008 SCRATCH (RW, 32 bits); 0xE000 TIMER (RW, 32 bits).
REQ-017 SHALL apply byte-lane enables to peripheral writes identically to RAM.
REQ-018 SHALL return 32'h0 for reads of unmapped peripheral offsets and ignore writes to them and to SWITCH.
REQ-019 SHALL synchronize switch through two flops; SWITCH reads return the synchronized value.
REQ-020 SHALL increment TIMER by 1 every cycle, wrapping 32'hFFFFFFFF -> 32'h0.
REQ-021 SHALL, on a TIMER write, load written lanes that cycle (write wins over increment); unwritten lanes keep the pre-increment value; increments resume next cycle.
REQ-022 SHALL return on a TIMER read the value present in the cycle the read is sampled.
REQ-023 SHALL drive led directly from the LED register, no extra latency.

Reset
REQ-024 SHALL, when resetn=0 at a clk edge, set data_sram_rdata=0, LED=0, SCRATCH=0, TIMER=0, switch synchronizer=0.
REQ-025 SHALL ignore any access presented in a cycle with resetn=0 (no RAM or register write, no rdata update).
REQ-026 SHALL NOT reset RAM contents.
REQ-027 SHALL accept accesses in the first cycle with resetn=1.

Configuration
REQ-028 SHALL, with SRAM_RESP_TIMER_EN defined, implement TIMER per REQ-020..022.
REQ-029 SHALL, without SRAM_RESP_TIMER_EN, omit TIMER flops; offset 0xE000 behaves as unmapped (reads 0, writes ignored).

Verification
REQ-030 SHALL cover: write 0xDEADBEEF wen=4'hF to 0x00000010, read next cycle -> rdata=0xDEADBEEF one cycle after read.
REQ-031 SHALL cover: word 0x11223344 at 0x20, write wen=4'b0101 wdata=0xAABBCCDD, read -> 0x11BB33DD.
REQ-032 SHALL cover: write LED 0x0000A5A5 at 0xBFAFF000 -> led=16'hA5A5 next cycle; read 0xBFAFF000 -> 0x0000A5A5; read 0xBFAF0100 -> 0.
REQ-033 SHALL cover (timer enabled): write TIMER 0xFFFFFFFE, idle 1 cycle, read -> 0xFFFFFFFF; read 2 cycles later -> 0x00000001; without macro read -> 0.
REQ-034 SHALL cover: switch=8'h3C, read SWITCH 3 cycles later -> 0x0000003C; write to SWITCH ignored.
REQ-035 SHALL cover: resetn low with write to 0x40 -> RAM at 0x40 unchanged, rdata=0, LED=0, SCRATCH=0.
